// File: rtl/blink_edit_ctrl.sv
// blink_edit_ctrl: four-digit blink editor with synchronized buttons and registered outputs.
// Build option EDIT_TIMEOUT_EN abandons an edit after TIMEOUT_TICKS tick pulses without a press.
module blink_edit_ctrl #(
  parameter int DIGIT_MAX     = 9,
  parameter int TIMEOUT_TICKS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_edit,
  input  logic        btn_next,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        tick,
  output logic [22:0] disps,
  output logic [19:0] value,
  output logic        commit,
  output logic        editing
);
  typedef enum logic [1:0] {IDLE = 2'd0, EDIT = 2'd1, COMMIT = 2'd2} state_t;
  localparam logic [4:0] DMAX = 5'(DIGIT_MAX);

  function automatic logic [4:0] digit_inc(input logic [4:0] d);
    if (d >= DMAX) return 5'd0;
    else return d + 5'd1;
  endfunction

  function automatic logic [4:0] digit_dec(input logic [4:0] d);
    if ((d == 5'd0) || (d > DMAX)) return DMAX;
    else return d - 5'd1;
  endfunction

  logic [3:0]      btn_s, sync1_r, sync2_r, prev_r, armed_r, rise_s, press_s;
  logic [1:0]      vld_r;
  state_t          state_r, state_nx;
  logic [3:0][4:0] work_r, work_nx;
  logic [1:0]      sel_r, sel_nx, idx_s;
  logic [19:0]     value_nx;
  logic [22:0]     disps_nx;
  logic            commit_nx, editing_nx;

`ifdef EDIT_TIMEOUT_EN
  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT_TICKS);
  logic [7:0] cnt_r, cnt_nx;
`else
  logic unused_tick_s;
  assign unused_tick_s = tick;
`endif

  assign btn_s  = {btn_edit, btn_next, btn_up, btn_down};
  assign rise_s = sync2_r & ~prev_r & armed_r;
  assign idx_s  = 2'd3 - sel_r;

  // Button synchronizers; a button is armed only after it is seen low once reset has released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
      prev_r  <= 4'b0000;
      armed_r <= 4'b0000;
      vld_r   <= 2'b00;
    end else begin
      sync1_r <= btn_s;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      vld_r   <= {vld_r[0], 1'b1};
      if (vld_r[1]) armed_r <= armed_r | ~sync2_r;
      else          armed_r <= armed_r;
    end
  end

  // One accepted press per cycle: edit > next > up > down.
  always_comb begin
    press_s = 4'b0000;
    if      (rise_s[3]) press_s = 4'b1000;
    else if (rise_s[2]) press_s = 4'b0100;
    else if (rise_s[1]) press_s = 4'b0010;
    else if (rise_s[0]) press_s = 4'b0001;
    else                press_s = 4'b0000;
  end

  // Next state, working digits and next registered outputs.
  always_comb begin
    state_nx = state_r;
    work_nx  = work_r;
    sel_nx   = sel_r;
    value_nx = value;
`ifdef EDIT_TIMEOUT_EN
    cnt_nx   = cnt_r;
`endif
    case (state_r)
      IDLE: begin
        if (press_s[3]) begin
          state_nx = EDIT;
          work_nx  = value;
          sel_nx   = 2'd0;
`ifdef EDIT_TIMEOUT_EN
          cnt_nx   = 8'd0;
`endif
        end else begin
          state_nx = IDLE;
        end
      end
      EDIT: begin
`ifdef EDIT_TIMEOUT_EN
        if (cnt_r >= CNT_MAX) begin
          state_nx = IDLE;
          work_nx  = '0;
          sel_nx   = 2'd0;
          cnt_nx   = 8'd0;
        end else begin
          if (|press_s)  cnt_nx = 8'd0;
          else if (tick) cnt_nx = cnt_r + 8'd1;
          else           cnt_nx = cnt_r;
`endif
          if (press_s[3]) begin
            state_nx = COMMIT;
            value_nx = work_r;
          end else if (press_s[2]) begin
            sel_nx = sel_r + 2'd1;
          end else if (press_s[1]) begin
            work_nx[idx_s] = digit_inc(work_r[idx_s]);
          end else if (press_s[0]) begin
            work_nx[idx_s] = digit_dec(work_r[idx_s]);
          end else begin
            state_nx = EDIT;
          end
`ifdef EDIT_TIMEOUT_EN
        end
`endif
      end
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    disps_nx   = {3'b000, value_nx};
    commit_nx  = 1'b0;
    editing_nx = 1'b0;
    if (state_nx == EDIT) begin
      disps_nx   = {1'b1, sel_nx, work_nx};
      editing_nx = 1'b1;
    end else if (state_nx == COMMIT) begin
      commit_nx = 1'b1;
    end else begin
      commit_nx = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      work_r  <= '0;
      sel_r   <= 2'd0;
      value   <= 20'd0;
      disps   <= 23'd0;
      commit  <= 1'b0;
      editing <= 1'b0;
`ifdef EDIT_TIMEOUT_EN
      cnt_r   <= 8'd0;
`endif
    end else begin
      state_r <= state_nx;
      work_r  <= work_nx;
      sel_r   <= sel_nx;
      value   <= value_nx;
      disps   <= disps_nx;
      commit  <= commit_nx;
      editing <= editing_nx;
`ifdef EDIT_TIMEOUT_EN
      cnt_r   <= cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_blink_edit_ctrl.sv
// Bench for blink_edit_ctrl: directed button/tick sequences checked against a behavioural model
// every cycle, plus hand-computed literal expectations.
module tb_blink_edit_ctrl;
  localparam int DMAX = 9;
  localparam int TMO  = 16;
`ifdef EDIT_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_edit = 1'b0, btn_next = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic        tick = 1'b0;
  logic [22:0] disps;
  logic [19:0] value;
  logic        commit, editing;

  int checks = 0;
  int fails = 0;
  int commit_cnt = 0;
  int c0;

  always #5 clk = ~clk;

  blink_edit_ctrl #(.DIGIT_MAX(DMAX), .TIMEOUT_TICKS(TMO)) dut (
    .clk(clk), .reset(reset), .btn_edit(btn_edit), .btn_next(btn_next),
    .btn_up(btn_up), .btn_down(btn_down), .tick(tick),
    .disps(disps), .value(value), .commit(commit), .editing(editing)
  );

  // Behavioural model: raw samples per edge, mode 0=idle 1=edit 2=commit.
  int         m_n = 0;
  logic [3:0] m_samp[$];
  int         m_mode = 0;
  int         m_sel = 0;
  int         m_cnt = 0;
  int         m_work[4] = '{0, 0, 0, 0};
  int         m_val[4]  = '{0, 0, 0, 0};

  function automatic logic [19:0] pack4(input int d[4]);
    return {5'(d[0]), 5'(d[1]), 5'(d[2]), 5'(d[3])};
  endfunction

  task automatic model_step(input logic [3:0] p);
    if (m_mode == 2) begin
      m_mode = 0;
    end else if (m_mode == 1 && TMO_EN && m_cnt >= TMO) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (p[3]) begin
        m_mode = 1; m_work = m_val; m_sel = 0; m_cnt = 0;
      end
    end else begin
      if (p != 4'b0000) m_cnt = 0;
      else if (tick) m_cnt = m_cnt + 1;
      if (p[3]) begin
        m_mode = 2; m_val = m_work;
      end else if (p[2]) m_sel = (m_sel + 1) % 4;
      else if (p[1]) m_work[m_sel] = (m_work[m_sel] == DMAX) ? 0 : m_work[m_sel] + 1;
      else if (p[0]) m_work[m_sel] = (m_work[m_sel] == 0) ? DMAX : m_work[m_sel] - 1;
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_n = 0; m_samp.delete(); m_mode = 0; m_sel = 0; m_cnt = 0;
      m_work = '{0, 0, 0, 0}; m_val = '{0, 0, 0, 0};
    end else begin
      m_n = m_n + 1;
      m_samp.push_back({btn_edit, btn_next, btn_up, btn_down});
      // a press is a low-to-high step between two real samples, acted on two edges later
      if (m_n >= 4) model_step(m_samp[m_n - 3] & ~m_samp[m_n - 4]);
      else model_step(4'b0000);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [22:0] e_disps;
    e_disps = (m_mode == 1) ? {1'b1, 2'(m_sel), pack4(m_work)} : {3'b000, pack4(m_val)};
    chk("disps", 32'(disps), 32'(e_disps));
    chk("value", 32'(value), 32'(pack4(m_val)));
    chk("commit", 32'(commit), 32'(m_mode == 2));
    chk("editing", 32'(editing), 32'(m_mode == 1));
    if (commit) commit_cnt = commit_cnt + 1;
  end

  task automatic press(input logic [3:0] m);
    @(negedge clk);
    {btn_edit, btn_next, btn_up, btn_down} = m;
    repeat (4) @(negedge clk);
    {btn_edit, btn_next, btn_up, btn_down} = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with btn_edit already held; it must not count as a press
    #1 reset = 1'b0;
    btn_edit = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_disps", 32'(disps), 32'h0);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_commit", 32'(commit), 32'h0);
    chk("rst_editing", 32'(editing), 32'h0);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("held_edit_ignored", 32'(editing), 32'h0);
    btn_edit = 1'b0;
    repeat (4) @(negedge clk);

    // edit press lands on the third edge after first sample
    @(negedge clk); btn_edit = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("edit_not_early", 32'(editing), 32'h0);
    @(posedge clk); #1;
    chk("edit_disps", 32'(disps), 32'h400000);
    chk("edit_editing", 32'(editing), 32'h1);
    @(negedge clk); btn_edit = 1'b0;
    repeat (4) @(negedge clk);

    // up x3, next, down, edit -> {3,9,0,0}
    repeat (3) press(4'b0010);
    press(4'b0100);
    press(4'b0001);
    c0 = commit_cnt;
    press(4'b1000);
    chk("commit_value", 32'(value), 32'({5'd3, 5'd9, 5'd0, 5'd0}));
    chk("commit_once", 32'(commit_cnt - c0), 32'd1);
    chk("commit_blink_off", 32'(disps[22]), 32'h0);

    // up ignored in idle
    press(4'b0010);
    chk("idle_up_ignored", 32'(disps), 32'({3'b000, 5'd3, 5'd9, 5'd0, 5'd0}));

    // next x5 wraps select to 1
    press(4'b1000);
    repeat (5) press(4'b0100);
    chk("sel_wrap", 32'(disps[21:20]), 32'd1);
    press(4'b1000);

    // digit 2 to 4, then up+down together -> 5
    press(4'b1000);
    repeat (2) press(4'b0100);
    repeat (4) press(4'b0010);
    chk("digit2_four", 32'(disps[9:5]), 32'd4);
    press(4'b0011);
    chk("up_beats_down", 32'(disps[9:5]), 32'd5);
    press(4'b1000);
    chk("value_3950", 32'(value), 32'({5'd3, 5'd9, 5'd5, 5'd0}));

    // tick timeout behaviour
    press(4'b1000);
    press(4'b0010);
    c0 = commit_cnt;
`ifdef EDIT_TIMEOUT_EN
    ticks(TMO);
    repeat (3) @(negedge clk);
    chk("timeout_idle", 32'(editing), 32'h0);
    chk("timeout_value", 32'(value), 32'({5'd3, 5'd9, 5'd5, 5'd0}));
    chk("timeout_no_commit", 32'(commit_cnt - c0), 32'd0);
    press(4'b1000);
    repeat (4) press(4'b0010);
`else
    ticks(100);
    chk("no_timeout_edit", 32'(editing), 32'h1);
    chk("no_timeout_blink", 32'(disps[22]), 32'h1);
    repeat (3) press(4'b0010);
`endif
    chk("digit0_seven", 32'(disps[19:15]), 32'd7);

    // async reset mid-edit
    c0 = commit_cnt;
    @(negedge clk); #2 reset = 1'b0;
    #1;
    chk("areset_disps", 32'(disps), 32'h0);
    chk("areset_value", 32'(value), 32'h0);
    chk("areset_editing", 32'(editing), 32'h0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("areset_no_commit", 32'(commit_cnt - c0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/blink_edit_ctrl.md
BLINK_EDIT_CTRL -- requirements
Module: blink_edit_ctrl

Interface
REQ-001 SHALL have parameter DIGIT_MAX, default 9: largest digit code produced (legal 1..15); up/down wrap at this value.
REQ-002 SHALL have parameter TIMEOUT_TICKS, default 16: tick pulses of inactivity in EDIT before the edit is abandoned (legal 1..255).
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port btn_edit  input  1: asynchronous button; enters edit or commits.
REQ-006 SHALL have port btn_next  input  1: asynchronous button; advances the selected digit.
REQ-007 SHALL have port btn_up  input  1: asynchronous button; increments the selected digit.
REQ-008 SHALL have port btn_down  input  1: asynchronous button; decrements the selected digit.
REQ-009 SHALL have port tick  input  1: single-cycle, clk-synchronous timeout strobe.
REQ-010 SHALL have port disps  output  23: display word; [22] blink enable, [21:20] blink digit select, [19:15]/[14:10]/[9:5]/[4:0] digits 0..3 (digit 0 leftmost).
REQ-011 SHALL have port value  output  20: committed digits, same packing as disps[19:0].
REQ-012 SHALL have port commit  output  1: one-cycle pulse when value is updated.
REQ-013 SHALL have port editing  output  1: high while in EDIT.

Function
REQ-014 SHALL pass each button through a 2-flop synchronizer and a rising-edge detector; an accepted press updates registered outputs on the 3rd rising clk edge after the input is sampled high.
REQ-015 SHALL accept at most one press per cycle, priority edit > next > up > down; lower-priority simultaneous edges are dropped.
REQ-016 SHALL implement states IDLE, EDIT, COMMIT, all outputs registered.
REQ-017 IDLE: disps[22]=0, disps[21:20]=0, disps[19:0]=value, editing=0; btn_edit -> EDIT.
REQ-018 IDLE->EDIT: working digits loaded from value, select=0, disps[22]=1, editing=1.
REQ-019 EDIT: disps[22]=1, disps[21:20]=select, disps[19:0]=working digits.
REQ-020 EDIT btn_next: select = select+1 mod 4 (3 wraps to 0).
REQ-021 EDIT btn_up: selected digit +1; DIGIT_MAX wraps to 0.
REQ-022 EDIT btn_down: selected digit -1; 0 wraps to DIGIT_MAX.
REQ-023 Digit codes SHALL stay within 0..DIGIT_MAX; reserved blank code 5'b10001 SHALL never be emitted in disps.
REQ-024 EDIT btn_edit -> COMMIT: value = working digits in that same edge.
REQ-025 COMMIT SHALL last exactly one cycle with commit=1, editing=0, disps[22]=0, then IDLE; presses during COMMIT are dropped.
REQ-026 In IDLE, next/up/down presses SHALL be ignored.

Reset
REQ-027 reset low SHALL asynchronously force IDLE, disps=0, value=0, commit=0, editing=0, select=0, working digits=0, synchronizer/edge flops=0, timeout counter=0.
REQ-028 reset asserted mid-EDIT SHALL discard the working digits; no commit pulse.
REQ-029 A button already high at reset release SHALL not produce a press until released and pressed again.

Configuration
REQ-030 Macro EDIT_TIMEOUT_EN defined: counter increments on tick in EDIT, clears on any accepted press and on EDIT entry; on reaching TIMEOUT_TICKS -> IDLE next edge, working digits discarded, value unchanged, commit stays 0.
REQ-031 EDIT_TIMEOUT_EN undefined: no counter is built, tick is ignored, EDIT persists until btn_edit or reset.

Verification
REQ-032 Reset, btn_edit press -> 3 clk later disps=23'h400000, editing=1.
REQ-033 From value=0: edit, up x3, next, down x1, edit -> value={5'd3,5'd9,5'd0,5'd0}, commit high exactly one cycle, disps[22]=0.
REQ-034 EDIT, next x5 -> disps[21:20]=1 (wrap 3->0).
REQ-035 btn_up and btn_down rising in same cycle on digit 2=4 -> digit 2=5 only.
REQ-036 EDIT_TIMEOUT_EN, TIMEOUT_TICKS=16: edit, up, 16 tick pulses -> IDLE, value unchanged, commit never high; undefined -> still EDIT after 100 ticks.
REQ-037 reset pulsed low mid-EDIT with working digit 0=7 -> immediately disps=0, value=0, editing=0.
